// File: rtl/rx_fsm.sv
// Serial-port receiver: 16x oversampled framing with 2-of-3 majority voting per bit,
// loading SBUF/RB8 and pulsing RI according to the RI-flag and multiprocessor rules.
module rx_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    input  logic       TC,
    input  logic [1:0] SM,
    input  logic       SM2,
    input  logic       REN,
    input  logic       SCON_RI,
    input  logic [7:0] AB,
    input  logic       rd_n,
    output logic [7:0] dout,
    output logic       RI,
    output logic       RB8,
    output logic       FE
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] BIT9  = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    localparam logic [1:0] MODE_8BIT = 2'b01;
    localparam logic [7:0] SBUF_ADDR = 8'h99;

    logic       rx_meta_reg, rxs_reg, rxs_prev_reg;
    logic       rxs;
    logic [2:0] state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] sbuf_reg, sbuf_next;
    logic [2:0] samp_reg, samp_next;
    logic [1:0] sm_frame_reg, sm_frame_next;
    logic       bit9_reg, bit9_next;
    logic       rb8_reg, rb8_next;
    logic       ri_reg, ri_next;
    logic       fe_reg, fe_next;

    logic       tc_mid, tc_end;
    logic       maj_live, maj_held;
    logic       abort, load;

    assign rxs = rxs_reg;

    assign tc_mid = TC && (cnt_reg == 4'd9);
    assign tc_end = TC && (cnt_reg == 4'd15);

    // At count 9 the third sample is still on the line; after that it is held in samp_reg[2].
    assign maj_live = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rxs) | (samp_reg[1] & rxs);
    assign maj_held = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & samp_reg[2]) |
                      (samp_reg[1] & samp_reg[2]);

    assign abort = (state_reg != IDLE) && (!REN || (SM != sm_frame_reg));

    assign load = !SCON_RI &&
                  (!SM2 || ((SM == MODE_8BIT) && maj_live) || ((SM != MODE_8BIT) && bit9_reg));

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        sbuf_next     = sbuf_reg;
        samp_next     = samp_reg;
        sm_frame_next = sm_frame_reg;
        bit9_next     = bit9_reg;
        rb8_next      = rb8_reg;
        ri_next       = 1'b0;
        fe_next       = 1'b0;

        if ((state_reg != IDLE) && TC) begin
            cnt_next = cnt_reg + 4'd1;
            case (cnt_reg)
                4'd7:    samp_next[0] = rxs;
                4'd8:    samp_next[1] = rxs;
                4'd9:    samp_next[2] = rxs;
                default: ;
            endcase
        end

        case (state_reg)
            IDLE: begin
                if (rxs_prev_reg && !rxs && REN && (SM != 2'b00)) begin
                    state_next    = START;
                    cnt_next      = 4'd0;
                    sm_frame_next = SM;
                end
            end
            START: begin
                if (tc_mid && maj_live) begin
                    state_next = IDLE;
                end else if (tc_end) begin
                    state_next   = DATA;
                    bit_cnt_next = 3'd0;
                end
            end
            DATA: begin
                if (tc_end) begin
                    shift_next   = {maj_held, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = (sm_frame_reg == MODE_8BIT) ? STOP : BIT9;
                    end
                end
            end
            BIT9: begin
                if (tc_end) begin
                    bit9_next  = maj_held;
                    state_next = STOP;
                end
            end
            STOP: begin
                // Decide mid stop bit so the line is free for the next start edge.
                if (tc_mid) begin
                    state_next = IDLE;
                    fe_next    = !maj_live;
                    if (load) begin
                        sbuf_next = shift_reg;
                        rb8_next  = (sm_frame_reg == MODE_8BIT) ? maj_live : bit9_reg;
                        ri_next   = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (abort) begin
            state_next = IDLE;
            sbuf_next  = sbuf_reg;
            rb8_next   = rb8_reg;
            ri_next    = 1'b0;
            fe_next    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg  <= 1'b1;
            rxs_reg      <= 1'b1;
            rxs_prev_reg <= 1'b1;
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 8'h00;
            sbuf_reg     <= 8'h00;
            samp_reg     <= 3'b000;
            sm_frame_reg <= 2'b00;
            bit9_reg     <= 1'b0;
            rb8_reg      <= 1'b0;
            ri_reg       <= 1'b0;
            fe_reg       <= 1'b0;
        end else begin
            rx_meta_reg  <= RxD;
            rxs_reg      <= rx_meta_reg;
            rxs_prev_reg <= rxs_reg;
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            sbuf_reg     <= sbuf_next;
            samp_reg     <= samp_next;
            sm_frame_reg <= sm_frame_next;
            bit9_reg     <= bit9_next;
            rb8_reg      <= rb8_next;
            ri_reg       <= ri_next;
            fe_reg       <= fe_next;
        end
    end

    assign dout = (!rd_n && (AB == SBUF_ADDR)) ? sbuf_reg : 8'h00;
    assign RI   = ri_reg;
    assign RB8  = rb8_reg;
    assign FE   = fe_reg;

endmodule

// File: tb/tb_rx_fsm.sv
// Bench for rx_fsm: directed frame table, multi-cycle corner sequences and random frames
// checked against a frame-level model of the receive/load rules.
module tb_rx_fsm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RxD = 1'b1;
    logic       TC = 1'b0;
    logic [1:0] SM = 2'b00;
    logic       SM2 = 1'b0;
    logic       REN = 1'b0;
    logic       SCON_RI = 1'b0;
    logic [7:0] AB = 8'h00;
    logic       rd_n = 1'b1;
    logic [7:0] dout;
    logic       RI, RB8, FE;

    int n_cmp = 0;
    int n_bad = 0;
    int tc_div = 0;

    int         ri_cycles = 0;
    int         fe_cycles = 0;
    logic       ri_prev = 1'b0;
    logic [7:0] dout_prev = 8'h00;
    logic [7:0] dout_at_ri = 8'h00;
    logic [7:0] dout_before_ri = 8'h00;

    // Frame-level model state: what SBUF and RB8 should hold now.
    logic [7:0] m_sbuf = 8'h00;
    logic       m_rb8 = 1'b0;

    typedef struct {
        logic [1:0] sm;
        logic       sm2;
        logic       sri;
        logic [7:0] data;
        logic       b9;
        logic       stop;
        logic       e_ri;
        logic [7:0] e_sbuf;
        logic       e_rb8;
        logic       e_fe;
    } vec_t;

    always #5 clk = ~clk;

    rx_fsm dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RxD     (RxD),
        .TC      (TC),
        .SM      (SM),
        .SM2     (SM2),
        .REN     (REN),
        .SCON_RI (SCON_RI),
        .AB      (AB),
        .rd_n    (rd_n),
        .dout    (dout),
        .RI      (RI),
        .RB8     (RB8),
        .FE      (FE)
    );

    always @(negedge clk) begin
        if (RI) begin
            ri_cycles <= ri_cycles + 1;
            if (!ri_prev) begin
                dout_at_ri     <= dout;
                dout_before_ri <= dout_prev;
            end
        end
        if (FE) fe_cycles <= fe_cycles + 1;
        ri_prev   <= RI;
        dout_prev <= dout;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        tc_div = (tc_div + 1) % 4;
        TC = (tc_div == 0);
    endtask

    task automatic hold_tc(input logic b, input int n);
        int k;
        k = 0;
        RxD = b;
        while (k < n) begin
            step();
            if (TC) k++;
        end
    endtask

    task automatic run_frame(input string tag, input logic [1:0] sm, input logic sm2,
                             input logic sri, input logic [7:0] data, input logic b9,
                             input logic stop, input int gap, input logic e_ri,
                             input logic [7:0] e_sbuf, input logic e_rb8, input logic e_fe);
        int ri0, fe0;
        logic [7:0] old_sbuf;
        old_sbuf = m_sbuf;
        SM = sm; SM2 = sm2; SCON_RI = sri; REN = 1'b1; rd_n = 1'b0; AB = 8'h99;
        ri0 = ri_cycles; fe0 = fe_cycles;
        hold_tc(1'b0, 16);
        for (int i = 0; i < 8; i++) hold_tc(data[i], 16);
        if (sm != 2'b01) hold_tc(b9, 16);
        hold_tc(stop, 16);
        hold_tc(1'b1, gap);
        repeat (2) step();
        check({tag, "_ri_cycles"}, ri_cycles - ri0, int'(e_ri));
        check({tag, "_fe_cycles"}, fe_cycles - fe0, int'(e_fe));
        check({tag, "_sbuf"}, dout, e_sbuf);
        check({tag, "_rb8"}, RB8, e_rb8);
        if (e_ri) begin
            check({tag, "_dout_in_load_cycle"}, dout_before_ri, old_sbuf);
            check({tag, "_dout_with_ri"}, dout_at_ri, e_sbuf);
        end
        m_sbuf = e_sbuf;
        m_rb8  = e_rb8;
        $display("frame %s sm=%b sm2=%b scon_ri=%b data=%02h b9=%b stop=%b -> RI=%0d FE=%0d SBUF=%02h RB8=%b",
                 tag, sm, sm2, sri, data, b9, stop, ri_cycles - ri0, fe_cycles - fe0, dout, RB8);
    endtask

    task automatic model_frame(input string tag, input logic [1:0] sm, input logic sm2,
                               input logic sri, input logic [7:0] data, input logic b9,
                               input logic stop, input int gap);
        logic lod;
        lod = !sri && (!sm2 || ((sm == 2'b01) ? stop : b9));
        run_frame(tag, sm, sm2, sri, data, b9, stop, gap, lod,
                  lod ? data : m_sbuf,
                  lod ? ((sm == 2'b01) ? stop : b9) : m_rb8,
                  !stop);
    endtask

    task automatic abort_frame(input string tag, input int kind);
        int ri0, fe0;
        SM = 2'b01; SM2 = 1'b0; SCON_RI = 1'b0; REN = 1'b1;
        ri0 = ri_cycles; fe0 = fe_cycles;
        hold_tc(1'b0, 16);
        hold_tc(1'b1, 16);
        hold_tc(1'b0, 8);
        if (kind == 0) REN = 1'b0;
        else SM = 2'b11;
        RxD = 1'b1;
        step();
        REN = 1'b1; SM = 2'b01;
        hold_tc(1'b1, 150);
        check({tag, "_ri_cycles"}, ri_cycles - ri0, 0);
        check({tag, "_fe_cycles"}, fe_cycles - fe0, 0);
        check({tag, "_sbuf"}, dout, m_sbuf);
        $display("abort %s -> RI=%0d FE=%0d SBUF=%02h", tag, ri_cycles - ri0, fe_cycles - fe0, dout);
    endtask

    initial begin
        vec_t tbl [0:7];
        int ri0, fe0;
        logic [1:0] r_sm;
        logic       r_stop;

        tbl[0] = '{2'b01, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        tbl[1] = '{2'b01, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
        tbl[2] = '{2'b01, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        tbl[3] = '{2'b10, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0};
        tbl[4] = '{2'b10, 1'b1, 1'b0, 8'h81, 1'b1, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0};
        tbl[5] = '{2'b01, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0};
        tbl[6] = '{2'b11, 1'b0, 1'b0, 8'h6B, 1'b0, 1'b1, 1'b1, 8'h6B, 1'b0, 1'b0};
        tbl[7] = '{2'b11, 1'b0, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b1};

        rd_n = 1'b0; AB = 8'h99;
        repeat (3) step();
        check("reset_ri", RI, 0);
        check("reset_fe", FE, 0);
        check("reset_rb8", RB8, 0);
        check("reset_sbuf", dout, 8'h00);
        rst_n = 1'b1;
        hold_tc(1'b1, 4);

        for (int i = 0; i < 8; i++) begin
            run_frame($sformatf("tbl%0d", i), tbl[i].sm, tbl[i].sm2, tbl[i].sri, tbl[i].data,
                      tbl[i].b9, tbl[i].stop, 12, tbl[i].e_ri, tbl[i].e_sbuf, tbl[i].e_rb8,
                      tbl[i].e_fe);
        end

        rd_n = 1'b1; AB = 8'h99; step();
        check("dout_rd_idle", dout, 8'h00);
        rd_n = 1'b0; AB = 8'h98; step();
        check("dout_wrong_addr", dout, 8'h00);
        AB = 8'h99; step();
        check("dout_read", dout, m_sbuf);

        // Short low glitch must be rejected as a false start.
        SM = 2'b01; REN = 1'b1; SM2 = 1'b0; SCON_RI = 1'b0;
        ri0 = ri_cycles; fe0 = fe_cycles;
        hold_tc(1'b0, 4);
        hold_tc(1'b1, 160);
        check("glitch_ri_cycles", ri_cycles - ri0, 0);
        check("glitch_fe_cycles", fe_cycles - fe0, 0);
        check("glitch_sbuf", dout, m_sbuf);
        $display("glitch -> RI=%0d FE=%0d SBUF=%02h", ri_cycles - ri0, fe_cycles - fe0, dout);
        model_frame("after_glitch", 2'b01, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 8);

        abort_frame("ren_drop", 0);
        model_frame("after_ren", 2'b01, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1, 8);
        abort_frame("sm_change", 1);
        model_frame("after_sm", 2'b01, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 8);

        for (int n = 0; n < 20; n++) begin
            r_sm   = 2'($urandom_range(1, 3));
            r_stop = ($urandom_range(0, 3) != 0);
            model_frame($sformatf("rnd%0d", n), r_sm, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom_range(0, 1)),
                        r_stop, r_stop ? $urandom_range(0, 3) : $urandom_range(1, 3));
        end

        // Reset in the middle of a frame discards it and clears SBUF/RB8.
        SM = 2'b01; REN = 1'b1; SM2 = 1'b0; SCON_RI = 1'b0;
        ri0 = ri_cycles;
        hold_tc(1'b0, 16);
        hold_tc(1'b0, 16);
        hold_tc(1'b1, 6);
        rst_n = 1'b0;
        RxD = 1'b1;
        #1;
        check("midreset_ri", RI, 0);
        check("midreset_fe", FE, 0);
        check("midreset_rb8", RB8, 0);
        check("midreset_sbuf", dout, 8'h00);
        repeat (3) step();
        rst_n = 1'b1;
        hold_tc(1'b1, 160);
        check("midreset_ri_cycles", ri_cycles - ri0, 0);
        check("midreset_sbuf_after", dout, 8'h00);
        $display("midframe reset -> RI=%0d SBUF=%02h RB8=%b", ri_cycles - ri0, dout, RB8);
        m_sbuf = 8'h00;
        m_rb8  = 1'b0;
        model_frame("after_reset", 2'b01, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
